// File: rtl/dot_acc.sv
// Streaming signed fixed-point dot-product accumulator: three-stage pipeline
// (input register, rounded/saturated product, saturating accumulator) with one result per frame.
module dot_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  sat_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [W-1:0]  MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] MAX_W = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_W = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] HALF  = PW'(1) << (FRAC_BITS - 1);

    logic en;
    logic take;

    logic [LEN_WIDTH-1:0] count_reg;

    logic                s1_valid_reg;
    logic                s1_last_reg;
    logic signed [W-1:0] s1_a_reg;
    logic signed [W-1:0] s1_b_reg;

    logic                s2_valid_reg;
    logic                s2_last_reg;
    logic                s2_psat_reg;
    logic signed [W-1:0] s2_prod_reg;

    logic signed [W-1:0] acc_reg;
    logic                sticky_reg;
    logic [W-1:0]        sum_reg;
    logic                sat_reg;
    logic                out_valid_reg;

    // The whole pipeline stalls only while a finished result waits for the consumer.
    assign en      = !(out_valid_reg && !ready_i);
    assign ready_o = en;
    assign take    = valid_i && en;

    assign sum_o   = sum_reg;
    assign sat_o   = sat_reg;
    assign valid_o = out_valid_reg;

    // Product: full-width multiply, round half up, clamp to the sample range.
    logic signed [PW-1:0] prod_full;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] prod_shift;
    logic signed [W-1:0]  prod_next;
    logic                 psat_next;

    always_comb begin
        prod_full  = s1_a_reg * s1_b_reg;
        prod_rnd   = prod_full + HALF;
        prod_shift = prod_rnd >>> FRAC_BITS;
        psat_next  = 1'b0;
        if (prod_shift > MAX_W) begin
            prod_next = MAX_V;
            psat_next = 1'b1;
        end else if (prod_shift < MIN_W) begin
            prod_next = MIN_V;
            psat_next = 1'b1;
        end else begin
            prod_next = prod_shift[W-1:0];
        end
    end

    // Accumulation is clamped on every add, one guard bit detects overflow.
    logic signed [W:0]   sum_wide;
    logic signed [W-1:0] sum_next;
    logic                asat_next;

    always_comb begin
        sum_wide  = {acc_reg[W-1], acc_reg} + {s2_prod_reg[W-1], s2_prod_reg};
        asat_next = sum_wide[W] != sum_wide[W-1];
        if (asat_next) begin
            sum_next = sum_wide[W] ? MIN_V : MAX_V;
        end else begin
            sum_next = sum_wide[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (take) begin
            if (count_reg == '0) begin
                count_reg <= len_i;
            end else begin
                count_reg <= count_reg - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (en) begin
            s1_valid_reg <= valid_i;
            s1_a_reg     <= a_i;
            s1_b_reg     <= b_i;
            s1_last_reg  <= (count_reg == '0) ? (len_i == '0) : (count_reg == LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_psat_reg  <= 1'b0;
            s2_prod_reg  <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            s2_psat_reg  <= psat_next;
            s2_prod_reg  <= prod_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg       <= '0;
            sticky_reg    <= 1'b0;
            sum_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (en) begin
            // en implies any held result is being consumed this cycle.
            out_valid_reg <= s2_valid_reg && s2_last_reg;
            if (s2_valid_reg) begin
                if (s2_last_reg) begin
                    sum_reg    <= sum_next;
                    sat_reg    <= sticky_reg | s2_psat_reg | asat_next;
                    acc_reg    <= '0;
                    sticky_reg <= 1'b0;
                end else begin
                    acc_reg    <= sum_next;
                    sticky_reg <= sticky_reg | s2_psat_reg | asat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: directed scenarios plus randomized frames with random backpressure,
// checked against an integer-arithmetic frame model.
module tb_dot_acc;

    localparam int W = 16;
    localparam int F = 15;
    localparam int L = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [L-1:0] len_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] sum_o;
    logic         sat_o;
    logic         valid_o;
    logic         ready_i = 1'b1;

    dot_acc #(.DATA_WIDTH(W), .FRAC_BITS(F), .LEN_WIDTH(L)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .len_i(len_i), .a_i(a_i), .b_i(b_i),
        .valid_i(valid_i), .ready_o(ready_o), .sum_o(sum_o), .sat_o(sat_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] sum;
        logic         sat;
        int           cyc;
    } result_t;

    result_t got[$];
    logic [W-1:0] exp_sum[$];
    logic         exp_sat[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  bp_rand = 1'b0;
    bit  ready_hold = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #2;
        ready_i = bp_rand ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) got.push_back('{sum_o, sat_o, cyc});
    end

    // Reference: each frame is a list of integer pairs; products round half up and
    // clamp, and the running total clamps after every addition.
    function automatic void model_frame(input int qa[$], input int qb[$],
                                        output logic [W-1:0] s, output logic sat);
        longint maxv = (longint'(1) <<< (W - 1)) - 1;
        longint minv = -(longint'(1) <<< (W - 1));
        longint acc = 0;
        longint p;
        sat = 1'b0;
        foreach (qa[i]) begin
            p = (longint'(qa[i]) * longint'(qb[i]) + (longint'(1) <<< (F - 1))) >>> F;
            if (p > maxv) begin p = maxv; sat = 1'b1; end
            if (p < minv) begin p = minv; sat = 1'b1; end
            acc = acc + p;
            if (acc > maxv) begin acc = maxv; sat = 1'b1; end
            if (acc < minv) begin acc = minv; sat = 1'b1; end
        end
        s = acc[W-1:0];
    endfunction

    // Tasks start and end right at a rising edge; inputs change 2 time units later.
    task automatic push(input int len, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        #2;
        len_i = L'(len); a_i = a; b_i = b; valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_o) begin
            t++;
            if (t > 500) begin
                n_cmp++; n_err++;
                $display("FAIL push_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, t);
                break;
            end
            @(negedge clk_i);
        end
        acc_cyc = cyc;
        @(posedge clk_i);
    endtask

    task automatic idle(input int n);
        #2;
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got.size() < n && t < 2000) begin
            @(posedge clk_i);
            t++;
        end
        n_cmp++;
        if (got.size() < n) begin
            n_err++;
            $display("FAIL wait_out: got %0d results, required %0d", got.size(), n);
        end
    endtask

    task automatic pulse_reset(input int n);
        #2;
        valid_i = 1'b0; rst_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        got.delete();
        @(posedge clk_i);
    endtask

    task automatic test_reset();
        pulse_reset(3);
        @(negedge clk_i);
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", valid_o); end
        n_cmp++; if (sum_o !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h, required 0000", sum_o); end
        n_cmp++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %0b, required 0", sat_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b, required 1", ready_o); end
        @(posedge clk_i);
        idle(10);
        n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL reset_idle: got %0d outputs, required 0", got.size()); end
    endtask

    task automatic test_basic();
        got.delete();
        repeat (3) push(2, 16'h4000, 16'h4000);
        idle(8);
        wait_out(1);
        n_cmp++; if (got.size() != 1) begin n_err++; $display("FAIL basic_count: got %0d, required 1", got.size()); end
        if (got.size() >= 1) begin
            n_cmp++; if (got[0].sum !== 16'h6000) begin n_err++; $display("FAIL basic_sum: got %h, required 6000", got[0].sum); end
            n_cmp++; if (got[0].sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %0b, required 0", got[0].sat); end
            n_cmp++; if (got[0].cyc - acc_cyc != 3) begin n_err++; $display("FAIL basic_latency: got %0d, required 3", got[0].cyc - acc_cyc); end
        end
        $display("basic: sum=%h sat=%0b", sum_o, sat_o);
    endtask

    task automatic test_rounding();
        got.delete();
        push(0, 16'h0001, 16'h4000);
        push(0, 16'h8000, 16'h8000);
        idle(6);
        wait_out(2);
        if (got.size() >= 2) begin
            n_cmp++; if (got[0].sum !== 16'h0001) begin n_err++; $display("FAIL round_sum: got %h, required 0001", got[0].sum); end
            n_cmp++; if (got[0].sat !== 1'b0) begin n_err++; $display("FAIL round_sat: got %0b, required 0", got[0].sat); end
            n_cmp++; if (got[1].sum !== 16'h7FFF) begin n_err++; $display("FAIL psat_sum: got %h, required 7fff", got[1].sum); end
            n_cmp++; if (got[1].sat !== 1'b1) begin n_err++; $display("FAIL psat_sat: got %0b, required 1", got[1].sat); end
        end
        $display("rounding: %0d results", got.size());
    endtask

    task automatic test_back_to_back();
        got.delete();
        push(2, 16'h6000, 16'h7FFF);
        push(2, 16'h6000, 16'h7FFF);
        push(2, 16'hC000, 16'h7FFF);
        push(0, 16'h4000, 16'h4000);
        idle(6);
        wait_out(2);
        if (got.size() >= 2) begin
            n_cmp++; if (got[0].sum !== 16'h4000) begin n_err++; $display("FAIL clamp_sum: got %h, required 4000", got[0].sum); end
            n_cmp++; if (got[0].sat !== 1'b1) begin n_err++; $display("FAIL clamp_sat: got %0b, required 1", got[0].sat); end
            n_cmp++; if (got[1].sum !== 16'h2000) begin n_err++; $display("FAIL b2b_sum: got %h, required 2000", got[1].sum); end
            n_cmp++; if (got[1].sat !== 1'b0) begin n_err++; $display("FAIL b2b_sat: got %0b, required 0", got[1].sat); end
            n_cmp++; if (got[1].cyc - got[0].cyc != 1) begin n_err++; $display("FAIL b2b_gap: got %0d, required 1", got[1].cyc - got[0].cyc); end
        end
        $display("back_to_back: %0d results", got.size());
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        got.delete();
        ready_hold = 1'b0;
        @(posedge clk_i);
        push(1, 16'h3000, 16'h2000);
        push(1, 16'hE000, 16'h4000);
        push(0, 16'h5000, 16'h5000);
        idle(6);
        @(negedge clk_i);
        held = sum_o;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %0b, required 0", ready_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b, required 1", valid_o); end
        // 0x3000*0x2000 -> 0x0C00, 0xE000*0x4000 -> 0xF000, sum 0xFC00
        n_cmp++; if (sum_o !== 16'hFC00) begin n_err++; $display("FAIL bp_sum: got %h, required fc00", sum_o); end
        repeat (4) @(negedge clk_i);
        n_cmp++; if (sum_o !== held || sat_o !== 1'b0) begin n_err++; $display("FAIL bp_stable: got %h/%0b, required %h/0", sum_o, sat_o, held); end
        @(posedge clk_i);
        ready_hold = 1'b1;
        wait_out(2);
        idle(6);
        n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d, required 2", got.size()); end
        if (got.size() >= 2) begin
            n_cmp++; if (got[0].sum !== 16'hFC00) begin n_err++; $display("FAIL bp_first: got %h, required fc00", got[0].sum); end
            n_cmp++; if (got[1].sum !== 16'h3200) begin n_err++; $display("FAIL bp_second: got %h, required 3200", got[1].sum); end
        end
        $display("backpressure: %0d results", got.size());
    endtask

    task automatic test_reset_midframe();
        got.delete();
        push(3, 16'h7000, 16'h7000);
        push(3, 16'h7000, 16'h7000);
        pulse_reset(1);
        push(0, 16'h2000, 16'h4000);
        idle(10);
        n_cmp++; if (got.size() != 1) begin n_err++; $display("FAIL midrst_count: got %0d, required 1", got.size()); end
        if (got.size() >= 1) begin
            n_cmp++; if (got[0].sum !== 16'h1000 || got[0].sat !== 1'b0) begin
                n_err++; $display("FAIL midrst_sum: got %h/%0b, required 1000/0", got[0].sum, got[0].sat);
            end
        end
        $display("reset_midframe: %0d results", got.size());
    endtask

    task automatic test_random();
        int qa[$];
        int qb[$];
        int len;
        logic [W-1:0] a, b, es;
        logic esat;
        got.delete(); exp_sum.delete(); exp_sat.delete();
        bp_rand = 1'b1;
        for (int f = 0; f < 25; f++) begin
            len = (f == 12) ? 255 : $urandom_range(0, 6);
            qa.delete(); qb.delete();
            for (int i = 0; i <= len; i++) begin
                a = W'($urandom);
                b = (f == 12) ? W'($urandom_range(0, 511) - 256) :
                    (($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 8191) - 4096));
                qa.push_back(int'($signed(a)));
                qb.push_back(int'($signed(b)));
                push(len, a, b);
            end
            model_frame(qa, qb, es, esat);
            exp_sum.push_back(es);
            exp_sat.push_back(esat);
        end
        idle(1);
        bp_rand = 1'b0;
        wait_out(exp_sum.size());
        idle(8);
        n_cmp++; if (got.size() != exp_sum.size()) begin n_err++; $display("FAIL rand_count: got %0d, required %0d", got.size(), exp_sum.size()); end
        for (int i = 0; i < exp_sum.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i].sum !== exp_sum[i] || got[i].sat !== exp_sat[i]) begin
                n_err++;
                $display("FAIL rand_frame%0d: got %h/%0b, required %h/%0b", i, got[i].sum, got[i].sat, exp_sum[i], exp_sat[i]);
            end
        end
        $display("random: %0d frames", got.size());
    endtask

    initial begin
        @(posedge clk_i);
        test_reset();
        test_basic();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
